// File: rtl/writeback_unit.sv
// Register file write-port driver: merges single-cycle ALU results with buffered
// LSU results and tracks long-latency destinations in a busy scoreboard.
module writeback_unit #(
  parameter int XLEN         = 32,
  parameter int LQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [4:0]                      alu_rd,
  input  logic [XLEN-1:0]                 alu_wd,
  input  logic                            lsu_valid,
  output logic                            lsu_ready,
  input  logic [4:0]                      lsu_rd,
  input  logic [XLEN-1:0]                 lsu_wd,
  input  logic                            issue_valid,
  input  logic                            issue_long,
  input  logic [4:0]                      issue_rd,
  input  logic [4:0]                      chk_rs1,
  input  logic [4:0]                      chk_rs2,
  output logic                            stall,
  output logic                            reg_we,
  output logic [4:0]                      rd,
  output logic [XLEN-1:0]                 wd,
  output logic [$clog2(LQ_DEPTH+1)-1:0]   pending
);

  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] wd;
  } entry_t;

  entry_t          mem_q [LQ_DEPTH];
  entry_t          mem_d [LQ_DEPTH];
  logic [AW-1:0]   head_ptr_q, head_ptr_d;
  logic [AW-1:0]   tail_ptr_q, tail_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic [31:0]     busy_q, busy_d;
  logic            reg_we_q, reg_we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic   fifo_empty, fifo_full, starved;
  logic   alu_win, pop, push, issue_set;
  entry_t head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(LQ_DEPTH));
  assign starved    = (starve_q >= SW'(STARVE_LIMIT));
  assign head       = mem_q[head_ptr_q];

  // An ALU result to x0 never claims the port, so the FIFO may drain that cycle.
  assign alu_win   = alu_valid && (alu_rd != 5'd0) && !starved;
  assign pop       = !alu_win && !fifo_empty;
  assign push      = lsu_valid && !fifo_full;

  assign stall     = busy_q[chk_rs1] | busy_q[chk_rs2] | (issue_valid & busy_q[issue_rd]);
  assign issue_set = issue_valid && issue_long && (issue_rd != 5'd0) && !stall;

  assign alu_ready = !(starved && !fifo_empty);
  assign lsu_ready = !fifo_full;
  assign pending   = count_q;
  assign reg_we    = reg_we_q;
  assign rd        = rd_q;
  assign wd        = wd_q;

  always_comb begin
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    if (push) begin
      mem_d[tail_ptr_q] = '{rd: lsu_rd, wd: lsu_wd};
      tail_ptr_d        = tail_ptr_q + AW'(1);
    end
    if (pop) begin
      head_ptr_d = head_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Set is applied after clear so a same-cycle issue keeps the bit busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[head.rd] = 1'b0;
    end
    if (issue_set) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    reg_we_d = 1'b0;
    rd_d     = rd_q;
    wd_d     = wd_q;
    if (alu_win) begin
      reg_we_d = 1'b1;
      rd_d     = alu_rd;
      wd_d     = alu_wd;
    end else if (pop && (head.rd != 5'd0)) begin
      reg_we_d = 1'b1;
      rd_d     = head.rd;
      wd_d     = head.wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      busy_q     <= '0;
      reg_we_q   <= 1'b0;
      rd_q       <= '0;
      wd_q       <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      busy_q     <= busy_d;
      reg_we_q   <= reg_we_d;
      rd_q       <= rd_d;
      wd_q       <= wd_d;
    end
  end

  // Storage needs no reset; occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
